// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the reset sequencer.
`timescale 1ns/1ps
package rst_seq_pkg;

  localparam int DEF_NUM_STAGES   = 3;
  localparam int DEF_PLL_RST_CYC  = 8;
  localparam int DEF_STAGE_DLY    = 16;
  localparam int DEF_LOCK_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clock domain.
`timescale 1ns/1ps
module rst_seq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: PLL reset, lock wait, staged reset release.
// Optional lock watchdog with retry is compiled in by defining RST_SEQ_LOCK_WDT_EN.
`timescale 1ns/1ps
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int PLL_RST_CYC  = DEF_PLL_RST_CYC,
  parameter int STAGE_DLY    = DEF_STAGE_DLY,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_res,
  input  logic                  i_pll_lock,
  input  logic                  i_soft_rst_req,
  output logic                  o_pll_rst,
  output logic [NUM_STAGES-1:0] o_res_n,
  output logic                  o_ready,
  output logic                  o_lock_err
);

  localparam int REL_CYC = NUM_STAGES * STAGE_DLY;
  localparam int CNT_MAX = max3(PLL_RST_CYC, REL_CYC, LOCK_TIMEOUT);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Terminal counts compare against the value before the increment,
  // so the counter never needs to hold the terminal value itself.
  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_CYC - 1);

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  lock_s;
  logic                  pll_rst_next;
  logic [NUM_STAGES-1:0] res_n_next;
  logic                  ready_next;

  rst_seq_sync2 u_lock_sync (
    .clk (i_clk),
    .rst (i_res),
    .d   (i_pll_lock),
    .q   (lock_s)
  );

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      o_pll_rst <= 1'b1;
      o_res_n   <= '0;
      o_ready   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      o_pll_rst <= pll_rst_next;
      o_res_n   <= res_n_next;
      o_ready   <= ready_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      S_PLL_RST: begin
        if (cnt == PLL_LAST) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = S_RELEASE;
          cnt_next   = '0;
        end
`ifdef RST_SEQ_LOCK_WDT_EN
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_next = S_PLL_RST;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        // Lock loss outranks a soft request arriving in the same cycle.
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else if (i_soft_rst_req) begin
          state_next = S_RELEASE;
          cnt_next   = '0;
        end else if (cnt == REL_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else if (i_soft_rst_req) begin
          state_next = S_RELEASE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_PLL_RST;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    pll_rst_next = (state_next == S_PLL_RST);
    res_n_next   = o_res_n;
    ready_next   = o_ready;
    unique case (state)
      S_RELEASE, S_RUN: begin
        if (!lock_s || i_soft_rst_req) begin
          res_n_next = '0;
          ready_next = 1'b0;
        end else if (state == S_RELEASE) begin
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (cnt == CNT_W'((k + 1) * STAGE_DLY - 1)) res_n_next[k] = 1'b1;
          end
          if (cnt == REL_LAST) ready_next = 1'b1;
        end
      end
      default: begin
        res_n_next = '0;
        ready_next = 1'b0;
      end
    endcase
  end

`ifdef RST_SEQ_LOCK_WDT_EN
  logic lock_err_next;

  assign lock_err_next = (state == S_WAIT_LOCK) && (state_next == S_PLL_RST);

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) o_lock_err <= 1'b0;
    else       o_lock_err <= lock_err_next;
  end
`else
  assign o_lock_err = 1'b0;
`endif

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 3: number of sequenced reset outputs (1..8).
REQ-002 The block SHALL have parameter PLL_RST_CYC, default 8: cycles o_pll_rst is held high per attempt (>=1).
REQ-003 The block SHALL have parameter STAGE_DLY, default 16: cycles between successive stage releases (>=1).
REQ-004 The block SHALL have parameter LOCK_TIMEOUT, default 1024: lock-wait limit in cycles, used only when the watchdog is compiled in.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port i_res, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port i_pll_lock, input, 1 bit: PLL lock, asynchronous to i_clk.
REQ-008 The block SHALL have port i_soft_rst_req, input, 1 bit: soft-reset request, one-cycle pulse, synchronous to i_clk.
REQ-009 The block SHALL have port o_pll_rst, output, 1 bit: PLL reset, active-high.
REQ-010 The block SHALL have port o_res_n, output, NUM_STAGES bits: per-stage resets, active-low; bit 0 is released first.
REQ-011 The block SHALL have port o_ready, output, 1 bit: high when all stages are released.
REQ-012 The block SHALL have port o_lock_err, output, 1 bit: one-cycle pulse on lock timeout.

Function
REQ-013 The block SHALL synchronise i_pll_lock through two flops (lock_s); all decisions SHALL use lock_s, giving 2 cycles of latency.
REQ-014 The block SHALL implement the states S_PLL_RST, S_WAIT_LOCK, S_RELEASE and S_RUN, with a single counter cnt sized $clog2 of the largest terminal count.
REQ-015 In S_PLL_RST, o_pll_rst SHALL be 1 and cnt SHALL count PLL_RST_CYC cycles, then move to S_WAIT_LOCK with cnt=0.
REQ-016 In S_WAIT_LOCK, o_pll_rst SHALL be 0, and lock_s=1 SHALL move to S_RELEASE with cnt=0.
REQ-017 In S_RELEASE, o_res_n[k] SHALL rise (k+1)*STAGE_DLY cycles after entry; once risen, a bit SHALL stay high until a lock loss or soft reset.
REQ-018 When o_res_n[NUM_STAGES-1] rises, o_ready SHALL rise in the same cycle and the state SHALL become S_RUN.
REQ-019 In S_RELEASE or S_RUN, lock_s=0 SHALL drive all o_res_n and o_ready to 0 on the next edge and move to S_WAIT_LOCK.
REQ-020 In S_RELEASE or S_RUN, i_soft_rst_req=1 SHALL drive all o_res_n and o_ready to 0 on the next edge and re-enter S_RELEASE with cnt=0; the PLL is not reset.
REQ-021 i_soft_rst_req SHALL be ignored in S_PLL_RST and S_WAIT_LOCK.
REQ-022 When lock loss and a soft request occur in the same cycle, the lock loss SHALL take priority.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 While i_res=1, the block SHALL immediately, asynchronously, set state=S_PLL_RST, cnt=0, o_pll_rst=1, o_res_n=all 0, o_ready=0, o_lock_err=0 and both synchroniser flops to 0.
REQ-025 After i_res deasserts, the block SHALL start the sequence from S_PLL_RST.
REQ-026 An i_res assertion at any point mid-sequence SHALL abort the sequence to the reset values.

Configuration
REQ-027 When RST_SEQ_LOCK_WDT_EN is defined, S_WAIT_LOCK SHALL count cycles.
REQ-028 With RST_SEQ_LOCK_WDT_EN defined, reaching LOCK_TIMEOUT cycles without lock_s SHALL pulse o_lock_err for 1 cycle and re-enter S_PLL_RST (retry, indefinitely).
REQ-029 When RST_SEQ_LOCK_WDT_EN is undefined, S_WAIT_LOCK SHALL wait forever, o_lock_err SHALL be tied to 0, and the port list SHALL be unchanged.

Structure
REQ-030 Package rst_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-031 Sub-module rst_seq_sync2 SHALL be the 2-flop synchroniser for i_pll_lock, with the same clock and reset as the parent.
REQ-032 The FSM and counter SHALL live in reset_sequencer.

Verification
All scenarios use the defaults (NUM_STAGES=3, PLL_RST_CYC=8, STAGE_DLY=16, LOCK_TIMEOUT=1024).
REQ-033 Cold start: release i_res at cycle 0 with i_pll_lock=1 from cycle 20 -> o_pll_rst high for cycles 0-7; o_res_n[0], [1] and [2] rise 16, 32 and 48 cycles after S_RELEASE entry (S_RELEASE is entered 2 cycles after lock is sampled); o_ready rises with o_res_n[2].
REQ-034 Soft reset: pulse i_soft_rst_req once in S_RUN -> next cycle o_res_n=000 and o_ready=0; o_pll_rst stays 0; the stages re-release at +16, +32 and +48.
REQ-035 Lock loss: drop i_pll_lock during S_RELEASE after o_res_n[0]=1 -> all o_res_n=0 three cycles later; state is S_WAIT_LOCK; restoring lock restarts the release.
REQ-036 Simultaneous events: soft request in the same cycle that lock_s falls -> state is S_WAIT_LOCK, not S_RELEASE.
REQ-037 Watchdog with RST_SEQ_LOCK_WDT_EN defined: i_pll_lock held 0 -> o_lock_err pulses after 1024 cycles in S_WAIT_LOCK, then o_pll_rst high for 8 cycles, repeating.
REQ-038 Watchdog without RST_SEQ_LOCK_WDT_EN: i_pll_lock held 0 -> o_lock_err stays 0 for 5000 cycles, with no o_pll_rst retry.
